// File: rtl/vect_pkg.sv
// Shared defaults and types for the vector memory stage.
package vect_pkg;

   localparam int unsigned LANES  = 6;
   localparam int unsigned LANE_W = 24;
   localparam int unsigned IDX_W  = $clog2(LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      LOAD  = 2'd2,
      DRAIN = 2'd3
   } vstate_e;

endpackage

// File: rtl/mem_vect_seq_if.sv
// One-word data-memory port between the vector memory stage and memory.
interface mem_vect_seq_if
   import vect_pkg::*;
#(
   parameter int unsigned N = LANE_W
);

   logic [N-1:0] memAddr;
   logic [N-1:0] memWdata;
   logic         memWe;
   logic         memRe;
   logic [N-1:0] memRdata;

   modport master (
      output memAddr,
      output memWdata,
      output memWe,
      output memRe,
      input  memRdata
   );

   modport slave (
      input  memAddr,
      input  memWdata,
      input  memWe,
      input  memRe,
      output memRdata
   );

endinterface

// File: rtl/vect_lane_mux.sv
// Combinational lane extractor: picks lane sel out of an M-lane packed vector.
module vect_lane_mux
   import vect_pkg::*;
#(
   parameter int unsigned M = LANES,
   parameter int unsigned N = LANE_W
) (
   input  logic [M*N-1:0]         bus,
   input  logic [$clog2(M)-1:0]   sel,
   output logic [N-1:0]           lane_c
);

   // Out-of-range selects read as zero rather than past the vector.
   always_comb begin
      lane_c = '0;
      if (int'(sel) < int'(M)) begin
         lane_c = bus[int'(sel)*N +: N];
      end
   end

endmodule

// File: rtl/mem_vect_seq.sv
// Vector memory stage: serialises vector loads/stores into single-word
// accesses and stalls upstream until done; non-memory results pass through.
module mem_vect_seq
   import vect_pkg::*;
#(
   parameter int unsigned N = LANE_W,
   parameter int unsigned M = LANES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             memRead,
   input  logic             memWrite,
   input  logic [M*N-1:0]   aluResult,
   input  logic [M*N-1:0]   storeData,
   mem_vect_seq_if.master   mem,
   output logic             stall,
   output logic [M*N-1:0]   resultOut,
   output logic             resultValid
);

   localparam int unsigned VW = M * N;
   localparam int unsigned IW = $clog2(M);

   vstate_e        state, state_d;
   logic [IW-1:0]  idx, idx_d, wr_lane;
   logic [N-1:0]   base, base_d;
   logic [VW-1:0]  sdata, sdata_d;
   logic [VW-1:0]  lbuf, lbuf_d;
   logic [VW-1:0]  res_d;
   logic           rv_d;
   logic [N-1:0]   wlane;
   logic           access;

   // State, lane counter and capture buffers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         base        <= '0;
         sdata       <= '0;
         lbuf        <= '0;
         resultOut   <= '0;
         resultValid <= 1'b0;
      end else begin
         state       <= state_d;
         idx         <= idx_d;
         base        <= base_d;
         sdata       <= sdata_d;
         lbuf        <= lbuf_d;
         resultOut   <= res_d;
         resultValid <= rv_d;
      end
   end

   // Next-state, lane sequencing and load-buffer fill.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      base_d  = base;
      sdata_d = sdata;
      lbuf_d  = lbuf;
      res_d   = resultOut;
      rv_d    = 1'b0;
      wr_lane = idx - IW'(1);

      case (state)
         IDLE: begin
            if (start) begin
               base_d  = aluResult[N-1:0];
               sdata_d = storeData;
               idx_d   = '0;
               if (memWrite) begin
                  state_d = STORE;
               end else if (memRead) begin
                  state_d = LOAD;
               end else begin
                  res_d = aluResult;
                  rv_d  = 1'b1;
               end
            end
         end
         STORE: begin
            idx_d = idx + IW'(1);
            if (idx == IW'(M - 1)) begin
               state_d = IDLE;
               idx_d   = '0;
            end
         end
         LOAD: begin
            // Read data for the previous lane arrives while this one issues.
            if (idx != '0) begin
               lbuf_d[int'(wr_lane)*N +: N] = mem.memRdata;
            end
            idx_d = idx + IW'(1);
            if (idx == IW'(M - 1)) begin
               state_d = DRAIN;
               idx_d   = '0;
            end
         end
         DRAIN: begin
            lbuf_d[(M-1)*N +: N] = mem.memRdata;
            res_d   = lbuf_d;
            rv_d    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   vect_lane_mux #(
      .M (M),
      .N (N)
   ) u_wmux (
      .bus    (sdata),
      .sel    (idx),
      .lane_c (wlane)
   );

   // Memory port decoded from state, counter and captured operands only.
   assign access       = (state == STORE) || (state == LOAD);
   assign stall        = (state != IDLE);
   assign mem.memWe    = (state == STORE);
   assign mem.memRe    = (state == LOAD);
   assign mem.memAddr  = access ? (base + N'(idx)) : '0;
   assign mem.memWdata = (state == STORE) ? wlane : '0;

endmodule

// File: doc/mem_vect_seq.md
# mem_vect_seq

Vector memory stage placed directly downstream of the vector execute stage. Each accepted vector load or store is serialised into M single-word accesses on a one-word data-memory port, and the pipeline is stalled until the transfer completes. Non-memory vector results pass through with one cycle of latency. The output feeds vector writeback.

## Interface

**Parameters**
- N, 24: lane width in bits; also the memory word and address width.
- M, 6: number of lanes.

**Ports**
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  valid instruction presented from the execute stage this cycle.
- memRead  in  1  instruction is a vector load.
- memWrite  in  1  instruction is a vector store.
- aluResult  in  M*N  execute-stage ALU result; lane 0 (bits N-1:0) is the base address for memory ops.
- storeData  in  M*N  vector store data (execute-stage RD3Out).
- memRdata  in  N  memory read data, valid one cycle after the read is issued.
- memAddr  out  N  memory word address.
- memWdata  out  N  memory write data.
- memWe  out  1  memory write enable.
- memRe  out  1  memory read enable.
- stall  out  1  hold upstream stages.
- resultOut  out  M*N  vector toward writeback.
- resultValid  out  1  resultOut valid this cycle (one-cycle pulse).

## Operation

- Lane i occupies bits [i*N +: N]; lane 0 is the LSB.
- States: IDLE, STORE, LOAD, DRAIN. A lane counter idx runs 0..M-1.
- Acceptance happens only in IDLE with start=1. At that edge the block captures base=aluResult[N-1:0], storeData and aluResult.
- While stall=1, start is ignored; upstream holds the next instruction.
- **Op selection on accept**
  - memWrite=1 → STORE, idx=0. memWrite wins if memRead is also 1.
  - memRead=1 only → LOAD, idx=0.
  - Neither → stay in IDLE. Next cycle: resultOut=captured aluResult, resultValid=1.
- **STORE** (each cycle)
  - memWe=1, memAddr=base+idx, memWdata=captured lane idx.
  - idx increments each cycle. After idx=M-1 → IDLE.
  - resultValid is never asserted for stores.
- **LOAD** (each cycle)
  - memRe=1, memAddr=base+idx. idx increments.
  - memRdata present in this cycle is written into result lane idx-1 when idx>0.
  - After idx=M-1 → DRAIN.
- **DRAIN**
  - Captures memRdata into lane M-1.
  - → IDLE, with resultValid=1 and resultOut=the loaded vector on the following cycle.
- **Address arithmetic:** base+idx is modulo 2^N. Example: base=0xFFFFFE gives lanes at 0xFFFFFE, 0xFFFFFF, 0x000000 … 0x000003.
- **Output hold:**
  - stall = (state != IDLE).
  - memWe/memRe are 0 outside STORE/LOAD.
  - memAddr/memWdata are 0 when no access is issued.
  - resultOut holds its last value between pulses.
- All outputs are driven from registers (state, idx, capture buffers) only.

## Timing

- **Reset:** at a clk edge with rst=1:
  - state=IDLE, idx=0.
  - all outputs 0, including resultOut.
  - any in-flight op is dropped; a partially completed store leaves earlier words written.
  - rst overrides start in the same cycle.
- Accept edge = cycle 0.
- **Non-memory op:** resultValid in cycle 1; stall never asserted.
- **Store:**
  - stall=1 and memWe=1 in cycles 1..M.
  - IDLE in cycle M+1; a new start is accepted at the end of cycle M+1.
- **Load:**
  - memRe=1 in cycles 1..M; DRAIN in cycle M+1, so stall=1 in cycles 1..M+1.
  - resultValid=1 in cycle M+2 with stall=0. A start in cycle M+2 is accepted.
- **Back-to-back non-memory ops:** one accepted per cycle, and resultValid stays high continuously.

## Structure

- **Shared package vect_pkg:**
  - lane count M and width N as global defaults.
  - the state enum typedef (IDLE, STORE, LOAD, DRAIN).
  - idx width constant $clog2(M).
- **Sub-module vect_lane_mux:** parameterised M/N combinational lane extractor (M*N bus, idx → N-bit lane). Used for memWdata selection.
- Lane write-back into the load buffer is done with indexed part-select in the top module.

## Test plan

- **Reset mid-load:** reset asserted in cycle 3 of a load → next cycle all outputs 0, state IDLE; a subsequent start is accepted normally.
- **Store:** base=0x000010, lanes 0xA0..0xA5 → memWe high for 6 cycles, addresses 0x10..0x15, data 0xA0..0xA5 in order; stall high for exactly 6 cycles; no resultValid.
- **Load:** base=0x000100, memory model returns addr^0x5A5A5A one cycle after memRe → resultValid in cycle 8 with lane i = (0x100+i)^0x5A5A5A; stall high cycles 1..7.
- **Wrap-around:** load at base=0xFFFFFE → addresses FFFFFE, FFFFFF, 000000, 000001, 000002, 000003.
- **Non-memory stream:** 4 back-to-back non-memory starts with distinct aluResult → 4 consecutive resultValid pulses, values in order, stall never high.
- **Simultaneous/ignored start:** memRead=memWrite=1 → executed as a store. A start asserted during stall is not accepted and produces no access.
